// File: rtl/gtp_mon_pkg.sv
// gtp_mon_pkg
//   Shared types and helpers for the GTP link-health monitor.
//   - lane_state_e : per-lane link state (DOWN/HUNT/UP)
//   - STAT_*       : bit positions inside the 4-bit status nibble
//   - sat_inc      : saturating increment for counters up to SAT_W bits wide
package gtp_mon_pkg;

  typedef enum logic [1:0] {
    ST_DOWN = 2'd0,
    ST_HUNT = 2'd1,
    ST_UP   = 2'd2
  } lane_state_e;

  localparam int STAT_DISPERR  = 0;
  localparam int STAT_NOTINTAB = 1;
  localparam int STAT_ALIGNED  = 2;
  localparam int STAT_COMMA    = 3;

  localparam int SAT_W = 32;

  // Increments value, holding at the all-ones value of a 'width'-bit counter.
  function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] value,
                                               input int               width);
    logic [SAT_W-1:0] max_val;
    max_val = (width >= SAT_W) ? '1 : ((SAT_W'(1) << width) - SAT_W'(1));
    return (value >= max_val) ? max_val : value + SAT_W'(1);
  endfunction

endpackage

// File: rtl/gtp_lane_monitor.sv
// gtp_lane_monitor
//   Link-state tracker for one 8b10b receive lane.
//   Ports:
//     clk, rst_n      clock, asynchronous active-low reset
//     aligned_i       byte alignment of the lane
//     err_i           any disparity / not-in-table error in this RX word
//     comma_i         any comma byte in this RX word
//     clr_i           clear both counters (wins over a same-cycle increment)
//     link_up_o       1 while the lane is UP (decoded from the state register)
//     link_up_nxt_o   next-state UP flag, used by the top for an aligned ALL_UP register
//     err_cnt_o       saturating count of error words seen in HUNT or UP
//     drop_cnt_o      saturating count of UP->DOWN transitions
module gtp_lane_monitor
  import gtp_mon_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int LOCK_COMMAS = 8,
  parameter int UNLOCK_ERRS = 4,
  parameter int WINDOW      = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             aligned_i,
  input  logic             err_i,
  input  logic             comma_i,
  input  logic             clr_i,
  output logic             link_up_o,
  output logic             link_up_nxt_o,
  output logic [CNT_W-1:0] err_cnt_o,
  output logic [CNT_W-1:0] drop_cnt_o
);

  localparam int GW = $clog2(LOCK_COMMAS + 1);
  localparam int WW = $clog2(WINDOW);
  localparam int EW = $clog2(UNLOCK_ERRS + 1);

  localparam logic [GW-1:0] GOOD_LAST   = GW'(LOCK_COMMAS - 1);
  localparam logic [WW-1:0] WCNT_LAST   = WW'(WINDOW - 1);
  localparam logic [EW-1:0] ERRWIN_LAST = EW'(UNLOCK_ERRS - 1);

  lane_state_e      state_q, state_d;
  logic [GW-1:0]    good_q, good_d;
  logic [WW-1:0]    wcnt_q, wcnt_d;
  logic [EW-1:0]    errwin_q, errwin_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic             wrap;
  logic             err_inc;
  logic             drop;

  // NOTE: every variable gets a default before the case so no path leaves
  // it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d  = state_q;
    good_d   = good_q;
    wcnt_d   = '0;      // window is only live in UP; zero elsewhere so UP entry starts clean
    errwin_d = '0;
    wrap     = 1'b0;
    case (state_q)
      ST_DOWN: begin
        good_d = '0;
        if (aligned_i) state_d = ST_HUNT;
      end
      ST_HUNT: begin
        if (!aligned_i) begin
          state_d = ST_DOWN;
        end else if (err_i) begin
          good_d = '0;
        end else if (comma_i) begin
          if (good_q == GOOD_LAST) begin
            state_d = ST_UP;
            good_d  = '0;
          end else begin
            good_d = good_q + 1'b1;
          end
        end
      end
      ST_UP: begin
        if (!aligned_i) begin
          state_d = ST_DOWN;
        end else if (err_i && (errwin_q == ERRWIN_LAST)) begin
          state_d = ST_DOWN;
        end else begin
          // The word on the wrap cycle opens the next window.
          wrap     = (wcnt_q == WCNT_LAST);
          wcnt_d   = wrap ? '0 : wcnt_q + 1'b1;
          errwin_d = wrap ? EW'(err_i) : errwin_q + EW'(err_i);
        end
      end
      default: state_d = ST_DOWN;
    endcase
  end

  assign err_inc = err_i && (state_q != ST_DOWN);
  assign drop    = (state_q == ST_UP) && (state_d == ST_DOWN);

  always_comb begin
    err_cnt_d  = err_cnt_q;
    drop_cnt_d = drop_cnt_q;
    if (clr_i) begin
      err_cnt_d  = '0;
      drop_cnt_d = '0;
    end else begin
      if (err_inc) err_cnt_d  = CNT_W'(sat_inc(SAT_W'(err_cnt_q), CNT_W));
      if (drop)    drop_cnt_d = CNT_W'(sat_inc(SAT_W'(drop_cnt_q), CNT_W));
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, matching real hardware.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_DOWN;
      good_q     <= '0;
      wcnt_q     <= '0;
      errwin_q   <= '0;
      err_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      good_q     <= good_d;
      wcnt_q     <= wcnt_d;
      errwin_q   <= errwin_d;
      err_cnt_q  <= err_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign link_up_o     = (state_q == ST_UP);
  assign link_up_nxt_o = (state_d == ST_UP);
  assign err_cnt_o     = err_cnt_q;
  assign drop_cnt_o    = drop_cnt_q;

endmodule

// File: rtl/gtp_link_monitor.sv
// gtp_link_monitor
//   Per-lane 8b10b link-health monitor for NLANES GTP receive lanes.
//   Ports:
//     clk, rst_n           RX user clock, asynchronous active-low reset
//     rxdisperr_i          disparity error, lane l on bits [l*NB +: NB]
//     rxnotintable_i       not-in-table error, same packing
//     rxchariscomma_i      comma byte flags, same packing
//     rxbyteisaligned_i    byte alignment per lane
//     sel_i                lane selected for counters/status/clear
//     clr_cnt_i            one-cycle strobe: clear both counters of lane sel_i
//     link_up_o            1 = lane is UP
//     all_up_o             AND of all lane UP flags (same cycle as link_up_o)
//     err_cnt_o, drop_cnt_o, stat_o
//                          registered view of lane sel_i; zero when sel_i >= NLANES.
//                          stat_o = {comma, aligned, notintab, disperr} of the
//                          previous cycle's raw inputs.
module gtp_link_monitor
  import gtp_mon_pkg::*;
#(
  parameter int NLANES      = 4,
  parameter int NB          = 2,
  parameter int CNT_W       = 16,
  parameter int LOCK_COMMAS = 8,
  parameter int UNLOCK_ERRS = 4,
  parameter int WINDOW      = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NLANES*NB-1:0] rxdisperr_i,
  input  logic [NLANES*NB-1:0] rxnotintable_i,
  input  logic [NLANES*NB-1:0] rxchariscomma_i,
  input  logic [NLANES-1:0]    rxbyteisaligned_i,
  input  logic [2:0]           sel_i,
  input  logic                 clr_cnt_i,
  output logic [NLANES-1:0]    link_up_o,
  output logic                 all_up_o,
  output logic [CNT_W-1:0]     err_cnt_o,
  output logic [CNT_W-1:0]     drop_cnt_o,
  output logic [3:0]           stat_o
);

  logic [NLANES-1:0] lane_disp;
  logic [NLANES-1:0] lane_nit;
  logic [NLANES-1:0] lane_comma;
  logic [NLANES-1:0] lane_clr;
  logic [NLANES-1:0] lane_up_nxt;
  logic [CNT_W-1:0]  lane_err_cnt  [NLANES];
  logic [CNT_W-1:0]  lane_drop_cnt [NLANES];

  for (genvar l = 0; l < NLANES; l++) begin : g_lane
    assign lane_disp[l]  = |rxdisperr_i[l*NB +: NB];
    assign lane_nit[l]   = |rxnotintable_i[l*NB +: NB];
    assign lane_comma[l] = |rxchariscomma_i[l*NB +: NB];
    // An out-of-range select matches no lane, so the strobe is dropped.
    assign lane_clr[l]   = clr_cnt_i && (sel_i == 3'(l));

    gtp_lane_monitor #(
      .CNT_W       (CNT_W),
      .LOCK_COMMAS (LOCK_COMMAS),
      .UNLOCK_ERRS (UNLOCK_ERRS),
      .WINDOW      (WINDOW)
    ) u_lane (
      .clk           (clk),
      .rst_n         (rst_n),
      .aligned_i     (rxbyteisaligned_i[l]),
      .err_i         (lane_disp[l] | lane_nit[l]),
      .comma_i       (lane_comma[l]),
      .clr_i         (lane_clr[l]),
      .link_up_o     (link_up_o[l]),
      .link_up_nxt_o (lane_up_nxt[l]),
      .err_cnt_o     (lane_err_cnt[l]),
      .drop_cnt_o    (lane_drop_cnt[l])
    );
  end

  logic [CNT_W-1:0] sel_err, sel_drop;
  logic [3:0]       sel_stat;

  always_comb begin
    sel_err  = '0;
    sel_drop = '0;
    sel_stat = '0;
    for (int l = 0; l < NLANES; l++) begin
      if (sel_i == 3'(l)) begin
        sel_err                 = lane_err_cnt[l];
        sel_drop                = lane_drop_cnt[l];
        sel_stat[STAT_DISPERR]  = lane_disp[l];
        sel_stat[STAT_NOTINTAB] = lane_nit[l];
        sel_stat[STAT_ALIGNED]  = rxbyteisaligned_i[l];
        sel_stat[STAT_COMMA]    = lane_comma[l];
      end
    end
  end

  logic             all_up_q;
  logic [CNT_W-1:0] err_cnt_q, drop_cnt_q;
  logic [3:0]       stat_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      all_up_q   <= 1'b0;
      err_cnt_q  <= '0;
      drop_cnt_q <= '0;
      stat_q     <= '0;
    end else begin
      all_up_q   <= &lane_up_nxt;  // next-state AND keeps ALL_UP in step with LINK_UP
      err_cnt_q  <= sel_err;
      drop_cnt_q <= sel_drop;
      stat_q     <= sel_stat;
    end
  end

  assign all_up_o   = all_up_q;
  assign err_cnt_o  = err_cnt_q;
  assign drop_cnt_o = drop_cnt_q;
  assign stat_o     = stat_q;

endmodule

// File: tb/tb_gtp_link_monitor.sv
// tb_gtp_link_monitor
//   Directed bench for gtp_link_monitor: default instance plus a CNT_W=4
//   instance sharing the same stimulus for counter saturation.
module tb_gtp_link_monitor;

  localparam int NLANES = 4;
  localparam int NB     = 2;

  logic                 clk;
  logic                 rst_n;
  logic [NLANES*NB-1:0] disp, nit, comma;
  logic [NLANES-1:0]    aligned;
  logic [2:0]           sel;
  logic                 clr;

  logic [NLANES-1:0] link_up, link_up4;
  logic              all_up, all_up4;
  logic [15:0]       err_cnt, drop_cnt;
  logic [3:0]        err_cnt4, drop_cnt4;
  logic [3:0]        stat, stat4;

  int vectors     = 0;
  int miscompares = 0;

  gtp_link_monitor u_dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .rxdisperr_i       (disp),
    .rxnotintable_i    (nit),
    .rxchariscomma_i   (comma),
    .rxbyteisaligned_i (aligned),
    .sel_i             (sel),
    .clr_cnt_i         (clr),
    .link_up_o         (link_up),
    .all_up_o          (all_up),
    .err_cnt_o         (err_cnt),
    .drop_cnt_o        (drop_cnt),
    .stat_o            (stat)
  );

  gtp_link_monitor #(.CNT_W(4)) u_dut4 (
    .clk               (clk),
    .rst_n             (rst_n),
    .rxdisperr_i       (disp),
    .rxnotintable_i    (nit),
    .rxchariscomma_i   (comma),
    .rxbyteisaligned_i (aligned),
    .sel_i             (sel),
    .clr_cnt_i         (clr),
    .link_up_o         (link_up4),
    .all_up_o          (all_up4),
    .err_cnt_o         (err_cnt4),
    .drop_cnt_o        (drop_cnt4),
    .stat_o            (stat4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic set_lane(input int l, input logic al, input logic [1:0] cm,
                          input logic [1:0] dp, input logic [1:0] ni);
    aligned[l]       = al;
    comma[l*NB +: NB] = cm;
    disp[l*NB +: NB]  = dp;
    nit[l*NB +: NB]   = ni;
  endtask

  initial begin
    int   w;
    logic e;

    rst_n = 1'b0; disp = '0; nit = '0; comma = '0; aligned = '0; sel = 3'd0; clr = 1'b0;
    steps(3);
    rst_n = 1'b1;

    // 1: idle after reset
    steps(100);
    check("t1_link_up",  link_up,  4'h0);
    check("t1_all_up",   all_up,   1'b0);
    check("t1_err_cnt",  err_cnt,  16'h0);
    check("t1_drop_cnt", drop_cnt, 16'h0);
    check("t1_stat",     stat,     4'h0);
    check("t1_err_cnt4", err_cnt4, 4'h0);

    // 2: lane0 lock, error on 5th comma restarts the count
    set_lane(0, 1'b1, 2'b00, 2'b00, 2'b00); step();
    for (int i = 0; i < 4; i++) begin set_lane(0, 1'b1, 2'b01, 2'b00, 2'b00); step(); end
    set_lane(0, 1'b1, 2'b01, 2'b01, 2'b00); step();
    check("t2_stat_err_word", stat, 4'hD);
    for (int i = 0; i < 7; i++) begin set_lane(0, 1'b1, 2'b10, 2'b00, 2'b00); step(); end
    check("t2_not_up_after_7", link_up[0], 1'b0);
    set_lane(0, 1'b1, 2'b01, 2'b00, 2'b00); step();
    check("t2_up_after_8", link_up[0], 1'b1);
    set_lane(0, 1'b1, 2'b00, 2'b00, 2'b00); steps(2);
    check("t2_err_cnt",  err_cnt,  16'd1);
    check("t2_drop_cnt", drop_cnt, 16'd0);
    check("t2_stat_idle", stat, 4'h4);

    // 3: lane1, three errors keep it UP, fourth drops it
    sel = 3'd1;
    set_lane(1, 1'b1, 2'b00, 2'b00, 2'b00); step();
    for (int i = 0; i < 8; i++) begin set_lane(1, 1'b1, 2'b11, 2'b00, 2'b00); step(); end
    check("t3_up", link_up, 4'h3);
    set_lane(1, 1'b1, 2'b00, 2'b00, 2'b00); steps(5);
    set_lane(1, 1'b1, 2'b00, 2'b10, 2'b00); step();
    set_lane(1, 1'b1, 2'b00, 2'b00, 2'b00); steps(10);
    set_lane(1, 1'b1, 2'b00, 2'b00, 2'b10); step();
    check("t3_stat_nit", stat, 4'h6);
    set_lane(1, 1'b1, 2'b00, 2'b00, 2'b00); steps(10);
    set_lane(1, 1'b1, 2'b00, 2'b01, 2'b01); step();
    set_lane(1, 1'b1, 2'b00, 2'b00, 2'b00); steps(2);
    check("t3_still_up", link_up[1], 1'b1);
    check("t3_err_cnt3", err_cnt, 16'd3);
    check("t3_drop0",    drop_cnt, 16'd0);
    set_lane(1, 1'b1, 2'b00, 2'b01, 2'b00); step();
    check("t3_down", link_up[1], 1'b0);
    set_lane(1, 1'b0, 2'b00, 2'b00, 2'b00); steps(2);
    check("t3_err_cnt4", err_cnt,  16'd4);
    check("t3_drop1",    drop_cnt, 16'd1);

    // 4: lane2, three errors per window incl. one on a wrap cycle
    sel = 3'd2;
    set_lane(2, 1'b1, 2'b00, 2'b00, 2'b00); step();
    for (int i = 0; i < 8; i++) begin set_lane(2, 1'b1, 2'b01, 2'b00, 2'b00); step(); end
    check("t4_up", link_up[2], 1'b1);
    for (int t = 0; t < 5*1024; t++) begin
      w = t % 1024;
      e = (w == 100) || (w == 200) || ((t < 4*1024) ? (w == 300) : (w == 1023));
      set_lane(2, 1'b1, 2'b00, e ? 2'b01 : 2'b00, 2'b00);
      step();
    end
    set_lane(2, 1'b1, 2'b00, 2'b00, 2'b00); steps(2);
    check("t4_still_up", link_up[2], 1'b1);
    check("t4_err_cnt15", err_cnt, 16'd15);
    check("t4_drop0", drop_cnt, 16'd0);
    // window now holds 1 (wrap error); two more keep it UP, the third drops it
    set_lane(2, 1'b1, 2'b00, 2'b10, 2'b00); step();
    set_lane(2, 1'b1, 2'b00, 2'b00, 2'b00); step();
    set_lane(2, 1'b1, 2'b00, 2'b10, 2'b00); step();
    set_lane(2, 1'b1, 2'b00, 2'b00, 2'b00); step();
    check("t4_up_at3", link_up[2], 1'b1);
    set_lane(2, 1'b1, 2'b00, 2'b10, 2'b00); step();
    check("t4_down", link_up[2], 1'b0);
    set_lane(2, 1'b0, 2'b00, 2'b00, 2'b00); steps(2);
    check("t4_err_cnt18", err_cnt, 16'd18);
    check("t4_drop1", drop_cnt, 16'd1);

    // 6: all lanes UP, drop lane3, out-of-range select
    sel = 3'd0;
    for (int l = 1; l < 4; l++) set_lane(l, 1'b1, 2'b00, 2'b00, 2'b00);
    step();
    for (int i = 0; i < 8; i++) begin
      for (int l = 1; l < 4; l++) set_lane(l, 1'b1, 2'b01, 2'b00, 2'b00);
      step();
      if (i == 6) check("t6_all_up_early", all_up, 1'b0);
    end
    check("t6_link_up_all", link_up, 4'hF);
    check("t6_all_up", all_up, 1'b1);
    for (int l = 1; l < 4; l++) set_lane(l, 1'b1, 2'b00, 2'b00, 2'b00);
    step();
    set_lane(3, 1'b0, 2'b00, 2'b00, 2'b00); step();
    check("t6_link_up_drop3", link_up, 4'h7);
    check("t6_all_up_drop3", all_up, 1'b0);
    sel = 3'd5; clr = 1'b1; step();
    clr = 1'b0; step();
    check("t6_sel5_err",  err_cnt,  16'd0);
    check("t6_sel5_drop", drop_cnt, 16'd0);
    check("t6_sel5_stat", stat,     4'h0);
    sel = 3'd1; steps(2);
    check("t6_lane1_err_kept",  err_cnt,  16'd4);
    check("t6_lane1_drop_kept", drop_cnt, 16'd1);
    clr = 1'b1; step();
    clr = 1'b0; steps(2);
    check("t6_lane1_err_clr",  err_cnt,  16'd0);
    check("t6_lane1_drop_clr", drop_cnt, 16'd0);

    // 5: reset mid-operation, then saturation with CNT_W=4
    rst_n = 1'b0;
    #1;
    check("t5_rst_link_up", link_up, 4'h0);
    check("t5_rst_all_up",  all_up,  1'b0);
    check("t5_rst_stat",    stat,    4'h0);
    disp = '0; nit = '0; comma = '0; aligned = '0;
    steps(2);
    rst_n = 1'b1;
    step();
    sel = 3'd0;
    set_lane(0, 1'b1, 2'b00, 2'b00, 2'b00); step();
    for (int i = 0; i < 20; i++) begin set_lane(0, 1'b1, 2'b00, 2'b01, 2'b00); step(); end
    set_lane(0, 1'b1, 2'b00, 2'b00, 2'b00); steps(2);
    check("t5_sat_err_cnt4", err_cnt4, 4'hF);
    check("t5_err_cnt20", err_cnt, 16'd20);
    check("t5_hunt_not_up", link_up[0], 1'b0);
    clr = 1'b1; set_lane(0, 1'b1, 2'b00, 2'b01, 2'b00); step();
    clr = 1'b0; set_lane(0, 1'b1, 2'b00, 2'b00, 2'b00); steps(2);
    check("t5_clr_wins4", err_cnt4, 4'h0);
    check("t5_clr_wins",  err_cnt,  16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
